// File: rtl/button_conditioner.sv
// button_conditioner
// Synchronises and debounces a bank of active-low push buttons. Each button
// gets a 2-flop synchroniser and an independent four-state debounce FSM. The
// outputs are a clean active-low level plus one-cycle press and release strobes.
// Optional feature: define BTN_AUTOREPEAT_EN to add auto-repeat press strobes
// while a button is held. When it is undefined, no repeat logic is built.
module button_conditioner #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n_raw,
  output logic [N_BTN-1:0] btn_n_clean,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse
);

  // Debounce FSM encoding
  localparam logic [1:0] ST_UP      = 2'd0;
  localparam logic [1:0] ST_WAIT_DN = 2'd1;
  localparam logic [1:0] ST_DOWN    = 2'd2;
  localparam logic [1:0] ST_WAIT_UP = 2'd3;

  // The debounce counter only needs to reach DEBOUNCE_CYCLES-1, where it is
  // compared for acceptance.
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_ZERO      = '0;
  localparam logic [RPT_W-1:0] RPT_ONE       = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_DELAY_M1  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_M1 = RPT_W'(REPEAT_PERIOD - 1);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic             s1_reg;
      logic             s2_reg;
      logic [1:0]       state_reg;
      logic [1:0]       state_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             clean_reg;
      logic             clean_next;
      logic             press_reg;
      logic             press_next;
      logic             release_reg;
      logic             release_next;
      logic             accept_press;
      logic             accept_release;

      // Two-flop synchroniser; idles at 1 so reset looks like "released"
      always_ff @(posedge clock) begin
        if (reset) begin
          s1_reg <= 1'b1;
          s2_reg <= 1'b1;
        end else begin
          s1_reg <= btn_n_raw[gi];
          s2_reg <= s1_reg;
        end
      end

      // Debounce FSM: a WAIT state counts consecutive opposite samples and
      // falls back to the stable state on any bounce. The increment only
      // happens below CNT_LAST, so the counter can never wrap.
      always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        clean_next     = clean_reg;
        accept_press   = 1'b0;
        accept_release = 1'b0;
        case (state_reg)
          ST_UP: begin
            cnt_next = CNT_ZERO;
            if (!s2_reg) begin
              // This sample already counts as the first stable low
              state_next = ST_WAIT_DN;
              cnt_next   = CNT_ONE;
            end
          end
          ST_WAIT_DN: begin
            if (s2_reg) begin
              state_next = ST_UP;
              cnt_next   = CNT_ZERO;
            end else if (cnt_reg == CNT_LAST) begin
              state_next   = ST_DOWN;
              cnt_next     = CNT_ZERO;
              clean_next   = 1'b0;
              accept_press = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
          ST_DOWN: begin
            cnt_next = CNT_ZERO;
            if (s2_reg) begin
              state_next = ST_WAIT_UP;
              cnt_next   = CNT_ONE;
            end
          end
          ST_WAIT_UP: begin
            if (!s2_reg) begin
              state_next = ST_DOWN;
              cnt_next   = CNT_ZERO;
            end else if (cnt_reg == CNT_LAST) begin
              state_next     = ST_UP;
              cnt_next       = CNT_ZERO;
              clean_next     = 1'b1;
              accept_release = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
          default: begin
            state_next = ST_UP;
            cnt_next   = CNT_ZERO;
            clean_next = 1'b1;
          end
        endcase
      end

`ifdef BTN_AUTOREPEAT_EN
      logic [RPT_W-1:0] rpt_cnt_reg;
      logic [RPT_W-1:0] rpt_cnt_next;
      logic             rpt_first_reg;
      logic             rpt_first_next;
      logic             rpt_strobe;
      logic [RPT_W-1:0] rpt_target;

      // Repeat timer: counts only while stably DOWN (frozen in WAIT_UP). The
      // first interval is the initial delay, later ones are the repeat period.
      always_comb begin
        rpt_cnt_next   = rpt_cnt_reg;
        rpt_first_next = rpt_first_reg;
        rpt_strobe     = 1'b0;
        rpt_target     = rpt_first_reg ? RPT_DELAY_M1 : RPT_PERIOD_M1;
        if (accept_press || accept_release) begin
          rpt_cnt_next   = RPT_ZERO;
          rpt_first_next = 1'b1;
        end else if (state_reg == ST_DOWN && !s2_reg) begin
          if (rpt_cnt_reg == rpt_target) begin
            rpt_strobe     = 1'b1;
            rpt_cnt_next   = RPT_ZERO;
            rpt_first_next = 1'b0;
          end else begin
            rpt_cnt_next = rpt_cnt_reg + RPT_ONE;
          end
        end
      end

      // Repeat timer registers
      always_ff @(posedge clock) begin
        if (reset) begin
          rpt_cnt_reg   <= RPT_ZERO;
          rpt_first_reg <= 1'b1;
        end else begin
          rpt_cnt_reg   <= rpt_cnt_next;
          rpt_first_reg <= rpt_first_next;
        end
      end

      // Press strobe: accepted press or an auto-repeat tick
      always_comb begin
        press_next   = accept_press | rpt_strobe;
        release_next = accept_release;
      end
`else
      // Press strobe: accepted press only
      always_comb begin
        press_next   = accept_press;
        release_next = accept_release;
      end
`endif

      // FSM state and registered outputs
      always_ff @(posedge clock) begin
        if (reset) begin
          state_reg   <= ST_UP;
          cnt_reg     <= CNT_ZERO;
          clean_reg   <= 1'b1;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          state_reg   <= state_next;
          cnt_reg     <= cnt_next;
          clean_reg   <= clean_next;
          press_reg   <= press_next;
          release_reg <= release_next;
        end
      end

      assign btn_n_clean[gi]   = clean_reg;
      assign press_pulse[gi]   = press_reg;
      assign release_pulse[gi] = release_reg;
    end
  endgenerate

endmodule
